lowx_mem_arbiter: RTL and testbench
===================================

# lowx_mem_arbiter

Shares the single lower-level memory port between the instruction align buffer refill path (port 0) and the data cache refill path (port 1). It runs one transaction at a time and arbitrates round-robin between the ports. Each transaction is tagged with an ID, and a watchdog bounds how long a transaction may take. The block sits between the two refill clients and the memory interconnect.

## Interface
Parameters:
- XLEN, 32, address width.
- BLK_SIZE, 128, refill block width in bits.
- TIMEOUT, 1024, maximum cycles from grant to accepted response; must be at least 4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid_i  in  2  per-port request valid; held until that port's res_valid_o.
- req_addr_i  in  2×XLEN  per-port block address; low log2(BLK_SIZE/8) bits ignored.
- req_uncached_i  in  2  per-port uncached attribute.
- gnt_o  out  2  one-cycle grant pulse to the selected port.
- res_valid_o  out  2  one-cycle response pulse to the owning port.
- res_err_o  out  1  response is a timeout; qualified by res_valid_o.
- res_blk_o  out  BLK_SIZE  registered response block; shared by both ports.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream accepts the request.
- mem_req_addr_o  out  XLEN  latched address with block offset forced to 0.
- mem_req_uncached_o  out  1  latched uncached attribute.
- mem_req_id_o  out  2  transaction ID, {seq bit, port}.
- mem_res_valid_i  in  1  downstream response valid.
- mem_res_id_i  in  2  ID of the returned response.
- mem_res_blk_i  in  BLK_SIZE  returned block.

## Operation
FSM states and transitions:
- IDLE → REQ when any req_valid_i is high.
  - Grant one port; pulse its gnt_o.
  - Latch addr, uncached and owner.
  - Toggle seq_q; clear the watchdog counter.
- Round-robin selection:
  - When both ports are valid, grant the port that is not rr_q (last granted); rr_q ← granted port.
  - When only one port is valid, grant it; rr_q is still updated.
- REQ: mem_req_valid_o=1.
  - On mem_req_ready_i, go to WAIT (request dropped the next cycle).
- WAIT: a response is accepted only when mem_res_valid_i=1 and mem_res_id_i=={seq_q, owner}.
  - On acceptance, register the block and go to RESP.
  - Non-matching responses are discarded silently, in every state.
- RESP: res_valid_o[owner]=1 for one cycle with the registered block, then go to IDLE.
- Watchdog: a counter increments every cycle in REQ and WAIT.
  - When it reaches TIMEOUT-1, go to RESP with res_err_o=1 and res_blk_o=0.
  - mem_req_valid_o drops in the next cycle even without a handshake.
  - A later response carrying the stale ID is discarded by the ID check.
- Requesters keep request fields stable only until gnt_o. Changes after grant do not affect the transaction in flight.

## Timing
- Reset values:
  - State IDLE; rr_q=1, so port 0 wins the first tie; seq_q=0; counter 0.
  - Every output 0, including res_blk_o and mem_req_id_o.
- Reset asserted mid-transaction returns to IDLE at once. Responses that arrive later are dropped only if their ID mismatches the post-reset ID, so the interconnect is reset together with this block.
- All outputs are registered or decoded from state only; no combinational path from input to output.
- Latency:
  - req_valid_i rising in IDLE at cycle t → gnt_o and mem_req_valid_o at t+1.
  - mem_req_ready_i at cycle k → mem_req_valid_o low at k+1.
  - Accepted mem_res_valid_i at r → res_valid_o at r+1.
  - State is IDLE at r+2.
- Minimum back-to-back transaction period: 4 cycles with zero downstream latency.
- A requester must drop req_valid_i in the cycle after res_valid_o, or the arbiter treats it as a new request.
- mem_res_valid_i in the same cycle that the watchdog expires: the response wins, and res_err_o=0.

## Test plan
- Single port 0 request, addr 0x0000_1234, ready immediate, response 3 cycles later with blk 0xA5 pattern:
  - mem_req_addr_o=0x0000_1230 and mem_req_id_o=2'b10.
  - res_valid_o=2'b01 with blk 0xA5 pattern and res_err_o=0.
- Both ports request simultaneously after reset: port 0 is granted first, port 1 second with ID 2'b01. Then with both still requesting, grants alternate 0,1,0,1.
- mem_req_ready_i held low for 5 cycles → mem_req_valid_o stays 1 and mem_req_addr_o stays stable for all 6 cycles.
- Response with a wrong ID (2'b11 while 2'b10 is expected) → ignored; the correct ID response 2 cycles later is delivered.
- TIMEOUT=8, no response → res_valid_o with res_err_o=1 and blk=0 at cycle 8 after grant; a later stale response is dropped.
- rst_ni pulsed low during WAIT → all outputs are 0 asynchronously; after release, a new port 1 request is granted normally with ID 2'b11.

Source files
------------

// File: rtl/lowx_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-refill (port 0) and D-refill (port 1), one ID-tagged transaction at a time.
// Latency: grant 1 cycle after request, response 1 cycle after accept. Backpressure: mem_req_valid_o is held until ready or watchdog expiry.
module lowx_mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [1:0]               req_valid_i,
    input  logic [1:0][XLEN-1:0]     req_addr_i,
    input  logic [1:0]               req_uncached_i,
    output logic [1:0]               gnt_o,
    output logic [1:0]               res_valid_o,
    output logic                     res_err_o,
    output logic [BLK_SIZE-1:0]      res_blk_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [XLEN-1:0]          mem_req_addr_o,
    output logic                     mem_req_uncached_o,
    output logic [1:0]               mem_req_id_o,
    input  logic                     mem_res_valid_i,
    input  logic [1:0]               mem_res_id_i,
    input  logic [BLK_SIZE-1:0]      mem_res_blk_i
);

    localparam int OFF = $clog2(BLK_SIZE / 8);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic                rr_q, seq_q, owner_q, err_q, unc_q;
    logic [1:0]          gnt_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     addr_q;
    logic [BLK_SIZE-1:0] blk_q;

    logic sel, any_req, res_match, expired, accept, timeout;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{req_addr_i[0][OFF-1:0], req_addr_i[1][OFF-1:0]};

    // On a tie the port that did not win last time is chosen.
    assign sel       = (&req_valid_i) ? ~rr_q : req_valid_i[1];
    assign any_req   = |req_valid_i;
    assign res_match = mem_res_valid_i && (mem_res_id_i == {seq_q, owner_q});
    assign expired   = (cnt_q == CW'(TIMEOUT - 1));
    assign accept    = (state_q == WAIT) && res_match;
    assign timeout   = ((state_q == REQ) && expired) ||
                       ((state_q == WAIT) && expired && !res_match);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_req) state_d = REQ;
            REQ:  begin
                if (expired)              state_d = RESP;
                else if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: if (res_match || expired) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid_o = (state_q == REQ);
        res_valid_o     = 2'b00;
        res_err_o       = 1'b0;
        if (state_q == RESP) begin
            res_valid_o = owner_q ? 2'b10 : 2'b01;
            res_err_o   = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= 1'b1;
            seq_q   <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            unc_q   <= 1'b0;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            addr_q  <= '0;
            blk_q   <= '0;
        end else begin
            gnt_q <= 2'b00;
            if ((state_q == IDLE) && any_req) begin
                gnt_q   <= sel ? 2'b10 : 2'b01;
                rr_q    <= sel;
                owner_q <= sel;
                seq_q   <= ~seq_q;
                cnt_q   <= '0;
                addr_q  <= {req_addr_i[sel][XLEN-1:OFF], {OFF{1'b0}}};
                unc_q   <= req_uncached_i[sel];
            end
            if ((state_q == REQ) || (state_q == WAIT))
                cnt_q <= cnt_q + CW'(1);
            if (accept) begin
                blk_q <= mem_res_blk_i;
                err_q <= 1'b0;
            end else if (timeout) begin
                blk_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign gnt_o              = gnt_q;
    assign res_blk_o          = blk_q;
    assign mem_req_addr_o     = addr_q;
    assign mem_req_uncached_o = unc_q;
    assign mem_req_id_o       = {seq_q, owner_q};

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Directed bench for lowx_mem_arbiter with a short watchdog (TIMEOUT=8).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises downstream stalls, wrong IDs and watchdog expiry.
module tb_lowx_mem_arbiter;
    localparam int XLEN = 32;
    localparam int BLK  = 128;

    logic                 clk, rst_n;
    logic [1:0]           req_valid;
    logic [1:0][XLEN-1:0] req_addr;
    logic [1:0]           req_uncached;
    logic [1:0]           gnt, res_valid;
    logic                 res_err;
    logic [BLK-1:0]       res_blk;
    logic                 mem_req_valid, mem_req_ready, mem_req_uncached;
    logic [XLEN-1:0]      mem_req_addr;
    logic [1:0]           mem_req_id;
    logic                 mem_res_valid;
    logic [1:0]           mem_res_id;
    logic [BLK-1:0]       mem_res_blk;

    int n_cmp = 0;
    int n_err = 0;

    lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_uncached_i(req_uncached),
        .gnt_o(gnt), .res_valid_o(res_valid), .res_err_o(res_err), .res_blk_o(res_blk),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_uncached_o(mem_req_uncached),
        .mem_req_id_o(mem_req_id),
        .mem_res_valid_i(mem_res_valid), .mem_res_id_i(mem_res_id), .mem_res_blk_i(mem_res_blk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BLK-1:0] obs_v, input logic [BLK-1:0] exp_v);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One zero-latency transaction starting from IDLE with requests already driven.
    task automatic txn(input logic [1:0] exp_gnt, input logic [1:0] exp_id, input logic [BLK-1:0] blk);
        tick();
        chk("txn_gnt", gnt, exp_gnt);
        chk("txn_id", mem_req_id, exp_id);
        chk("txn_req_vld", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        chk("txn_req_drop", mem_req_valid, 1'b0);
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b1;
        mem_res_id    = exp_id;
        mem_res_blk   = blk;
        tick();
        chk("txn_res_vld", res_valid, exp_gnt);
        chk("txn_res_blk", res_blk, blk);
        chk("txn_res_err", res_err, 1'b0);
        mem_res_valid = 1'b0;
        tick();
        chk("txn_res_end", res_valid, 2'b00);
    endtask

    initial begin
        logic [BLK-1:0] pat_a5, pat_c3, pat_5a, pat_e1;
        pat_a5 = {16{8'hA5}};
        pat_c3 = {16{8'hC3}};
        pat_5a = {16{8'h5A}};
        pat_e1 = {16{8'hE1}};
        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_uncached = '0;
        mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_res_id = '0; mem_res_blk = '0;
        tick(); tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_res_vld", res_valid, 2'b00);
        chk("rst_err", res_err, 1'b0);
        chk("rst_blk", res_blk, {BLK{1'b0}});
        chk("rst_req_vld", mem_req_valid, 1'b0);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_id", mem_req_id, 2'b00);
        rst_n = 1'b1;

        // Single port 0 request, response three cycles after the handshake.
        req_addr[0] = 32'h0000_1234;
        req_valid   = 2'b01;
        tick();
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_req_vld", mem_req_valid, 1'b1);
        chk("t1_addr", mem_req_addr, 32'h0000_1230);
        chk("t1_id", mem_req_id, 2'b10);
        chk("t1_unc", mem_req_uncached, 1'b0);
        req_addr[0]   = 32'hDEAD_BEE0;
        mem_req_ready = 1'b1;
        tick();
        chk("t1_req_drop", mem_req_valid, 1'b0);
        chk("t1_gnt_pulse", gnt, 2'b00);
        mem_req_ready = 1'b0;
        tick(); tick();
        mem_res_valid = 1'b1; mem_res_id = 2'b10; mem_res_blk = pat_a5;
        tick();
        chk("t1_res_vld", res_valid, 2'b01);
        chk("t1_res_blk", res_blk, pat_a5);
        chk("t1_res_err", res_err, 1'b0);
        chk("t1_addr_held", mem_req_addr, 32'h0000_1230);
        mem_res_valid = 1'b0; req_valid = 2'b00;
        tick();
        chk("t1_idle", res_valid, 2'b00);

        // Both ports requesting continuously: grants alternate starting at port 0.
        rst_pulse();
        req_addr[0] = 32'h0000_0100; req_addr[1] = 32'h0000_0200;
        req_valid = 2'b11;
        txn(2'b01, 2'b10, pat_a5);
        txn(2'b10, 2'b01, pat_c3);
        txn(2'b01, 2'b10, pat_5a);
        txn(2'b10, 2'b01, pat_e1);
        txn(2'b01, 2'b10, pat_c3);
        txn(2'b10, 2'b01, pat_a5);

        // Downstream stalls for five cycles; request must stay stable.
        req_valid = 2'b01; req_addr[0] = 32'h0000_ABCD; req_uncached[0] = 1'b1;
        tick();
        chk("t3_gnt", gnt, 2'b01);
        chk("t3_id", mem_req_id, 2'b10);
        chk("t3_unc", mem_req_uncached, 1'b1);
        chk("t3_addr0", mem_req_addr, 32'h0000_ABC0);
        req_addr[0] = 32'h0; req_uncached[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_vld", mem_req_valid, 1'b1);
            chk("t3_stall_addr", mem_req_addr, 32'h0000_ABC0);
        end
        mem_req_ready = 1'b1;
        tick();
        chk("t3_req_drop", mem_req_valid, 1'b0);
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b1; mem_res_id = 2'b10; mem_res_blk = pat_5a;
        tick();
        chk("t3_res_vld", res_valid, 2'b01);
        chk("t3_res_err", res_err, 1'b0);
        mem_res_valid = 1'b0; req_valid = 2'b00;
        tick();

        // Wrong-ID response ignored, correct one two cycles later delivered.
        rst_pulse();
        req_valid = 2'b01; req_addr[0] = 32'h0000_2000;
        tick();
        chk("t4_id", mem_req_id, 2'b10);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b1; mem_res_id = 2'b11; mem_res_blk = pat_c3;
        tick();
        chk("t4_wrong_id", res_valid, 2'b00);
        mem_res_valid = 1'b0;
        tick();
        mem_res_valid = 1'b1; mem_res_id = 2'b10; mem_res_blk = pat_e1;
        tick();
        chk("t4_res_vld", res_valid, 2'b01);
        chk("t4_res_blk", res_blk, pat_e1);
        mem_res_valid = 1'b0; req_valid = 2'b00;
        tick();

        // Watchdog expiry on port 1, then a stale response.
        req_valid = 2'b10; req_addr[1] = 32'h0000_3000;
        tick();
        chk("t5_gnt", gnt, 2'b10);
        chk("t5_id", mem_req_id, 2'b01);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("t5_req_drop", mem_req_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_res", res_valid, 2'b00);
        end
        tick();
        chk("t5_to_vld", res_valid, 2'b10);
        chk("t5_to_err", res_err, 1'b1);
        chk("t5_to_blk", res_blk, {BLK{1'b0}});
        req_valid = 2'b00;
        tick();
        chk("t5_idle_vld", res_valid, 2'b00);
        chk("t5_idle_err", res_err, 1'b0);
        mem_res_valid = 1'b1; mem_res_id = 2'b01; mem_res_blk = pat_a5;
        tick();
        chk("t5_stale", res_valid, 2'b00);
        mem_res_valid = 1'b0;

        // Response arriving in the expiry cycle beats the watchdog.
        req_valid = 2'b01; req_addr[0] = 32'h0000_4000;
        tick();
        chk("t5b_id", mem_req_id, 2'b10);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        mem_res_valid = 1'b1; mem_res_id = 2'b10; mem_res_blk = pat_c3;
        tick();
        chk("t5b_res_vld", res_valid, 2'b01);
        chk("t5b_res_err", res_err, 1'b0);
        chk("t5b_res_blk", res_blk, pat_c3);
        mem_res_valid = 1'b0; req_valid = 2'b00;
        tick();

        // Asynchronous reset during WAIT.
        req_valid = 2'b01; req_addr[0] = 32'h0000_5550; req_uncached[0] = 1'b1;
        tick();
        chk("t6_id", mem_req_id, 2'b00);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_addr", mem_req_addr, 32'h0);
        chk("t6_arst_unc", mem_req_uncached, 1'b0);
        chk("t6_arst_blk", res_blk, {BLK{1'b0}});
        chk("t6_arst_req", mem_req_valid, 1'b0);
        chk("t6_arst_res", res_valid, 2'b00);
        chk("t6_arst_gnt", gnt, 2'b00);
        req_valid = 2'b00; req_uncached = 2'b00;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b10; req_addr[1] = 32'h0000_6000;
        txn(2'b10, 2'b11, pat_5a);
        req_valid = 2'b00;
        tick();
        chk("t6_no_regrant", gnt, 2'b00);

        if (n_err != 0)
            $error("FAIL summary: %0d of %0d comparisons mismatched", n_err, n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
